// File: rtl/edge_pkg.sv
// Shared definitions for the edge capture block: mode qualifier encodings,
// the per-channel debounce state type and the edge qualification helper.
package edge_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    typedef enum logic [1:0] {
        StLow,
        StRiseChk,
        StHigh,
        StFallChk
    } edge_state_e;

    function automatic logic qualify(logic [1:0] mode, logic rise, logic fall);
        if (mode == MODE_OFF) return 1'b0;
        return (rise && (mode == MODE_RISE || mode == MODE_BOTH)) ||
               (fall && (mode == MODE_FALL || mode == MODE_BOTH));
    endfunction

endpackage

// File: rtl/edge_chan.sv
// One capture channel: input synchronizer, debounce FSM with post-reset arming
// window, registered edge pulses, sticky flag and saturating edge counter.
module edge_chan
    import edge_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 3,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             level,
    input  logic [1:0]       mode,
    input  logic             clr,
    output logic             p_edge,
    output logic             n_edge,
    output logic             flag,
    output logic [CNT_W-1:0] cnt
);

    localparam int unsigned DebW      = $clog2(DEB_CYCLES + 1);
    localparam int unsigned ArmCycles = SYNC_STAGES + DEB_CYCLES;
    localparam int unsigned ArmW      = $clog2(ArmCycles + 1);
    localparam logic [DebW-1:0] DebMax = DebW'(DEB_CYCLES);
    localparam logic [ArmW-1:0] ArmMax = ArmW'(ArmCycles);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [ArmW-1:0]        arm_q, arm_d;
    edge_state_e            state_q, state_d;
    logic [DebW-1:0]        deb_q, deb_d, deb_inc;
    logic                   rise_q, rise_d, fall_q, fall_d;
    logic                   p_edge_q, p_edge_d, n_edge_q, n_edge_d;
    logic                   flag_q, flag_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   s, armed, qual;

    assign s       = sync_q[SYNC_STAGES-1];
    assign armed   = (arm_q == ArmMax);
    assign deb_inc = deb_q + DebW'(1);

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], level};
        arm_d    = armed ? arm_q : arm_q + ArmW'(1);
        state_d  = state_q;
        deb_d    = deb_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        // Until the synchronizer and debounce window have filled, track s directly
        // so a level already present at reset release never reports an edge.
        if (!armed) begin
            state_d = s ? StHigh : StLow;
            deb_d   = '0;
        end else begin
            unique case (state_q)
                StLow: begin
                    if (s) begin
                        if (DEB_CYCLES == 1) begin
                            state_d = StHigh;
                            rise_d  = 1'b1;
                        end else begin
                            state_d = StRiseChk;
                            deb_d   = DebW'(1);
                        end
                    end
                end
                StRiseChk: begin
                    if (!s) begin
                        state_d = StLow;
                        deb_d   = '0;
                    end else if (deb_inc == DebMax) begin
                        state_d = StHigh;
                        deb_d   = '0;
                        rise_d  = 1'b1;
                    end else begin
                        deb_d = deb_inc;
                    end
                end
                StHigh: begin
                    if (!s) begin
                        if (DEB_CYCLES == 1) begin
                            state_d = StLow;
                            fall_d  = 1'b1;
                        end else begin
                            state_d = StFallChk;
                            deb_d   = DebW'(1);
                        end
                    end
                end
                StFallChk: begin
                    if (s) begin
                        state_d = StHigh;
                        deb_d   = '0;
                    end else if (deb_inc == DebMax) begin
                        state_d = StLow;
                        deb_d   = '0;
                        fall_d  = 1'b1;
                    end else begin
                        deb_d = deb_inc;
                    end
                end
                default: begin
                    state_d = StLow;
                    deb_d   = '0;
                end
            endcase
        end

        p_edge_d = rise_q;
        n_edge_d = fall_q;

        qual   = qualify(mode, p_edge_q, n_edge_q);
        flag_d = clr ? qual : (flag_q | qual);
        cnt_d  = cnt_q;
        if (clr) begin
            cnt_d = qual ? CNT_W'(1) : '0;
        end else if (qual && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            arm_q    <= '0;
            state_q  <= StLow;
            deb_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            p_edge_q <= 1'b0;
            n_edge_q <= 1'b0;
            flag_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= sync_d;
            arm_q    <= arm_d;
            state_q  <= state_d;
            deb_q    <= deb_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            p_edge_q <= p_edge_d;
            n_edge_q <= n_edge_d;
            flag_q   <= flag_d;
            cnt_q    <= cnt_d;
        end
    end

    assign p_edge = p_edge_q;
    assign n_edge = n_edge_q;
    assign flag   = flag_q;
    assign cnt    = cnt_q;

endmodule

// File: rtl/edge_capture.sv
// Multi-channel debounced edge capture: one edge_chan per input bit, with
// bus packing of per-channel results and a combined interrupt.
module edge_capture #(
    parameter int unsigned CH          = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 3,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CH-1:0]       level,
    input  logic [2*CH-1:0]     mode,
    input  logic [CH-1:0]       clr,
    output logic [CH-1:0]       p_edge,
    output logic [CH-1:0]       n_edge,
    output logic [CH-1:0]       any_edge,
    output logic [CH-1:0]       flag,
    output logic [CH*CNT_W-1:0] cnt,
    output logic                irq
);

    for (genvar i = 0; i < CH; i++) begin : g_chan
        edge_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEB_CYCLES (DEB_CYCLES),
            .CNT_W      (CNT_W)
        ) u_chan (
            .clk    (clk),
            .reset_n(reset_n),
            .level  (level[i]),
            .mode   (mode[2*i +: 2]),
            .clr    (clr[i]),
            .p_edge (p_edge[i]),
            .n_edge (n_edge[i]),
            .flag   (flag[i]),
            .cnt    (cnt[i*CNT_W +: CNT_W])
        );
    end

    assign any_edge = p_edge | n_edge;
    assign irq      = |flag;

endmodule

// File: doc/edge_capture.md
EDGE_CAPTURE -- requirements
Module: edge_capture

Interface
REQ-001 Parameter CH, default 4: number of independent input channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flops per channel (>=2).
REQ-003 Parameter DEB_CYCLES, default 3: consecutive stable synced samples needed to accept a level change (>=1).
REQ-004 Parameter CNT_W, default 8: width of each per-channel edge counter.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 level  in  CH  asynchronous raw inputs, one bit per channel.
REQ-008 mode  in  2*CH  per-channel qualifier, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both.
REQ-009 clr  in  CH  per-channel synchronous clear of flag and counter.
REQ-010 p_edge  out  CH  one-cycle pulse on accepted rising edge, independent of mode.
REQ-011 n_edge  out  CH  one-cycle pulse on accepted falling edge, independent of mode.
REQ-012 any_edge  out  CH  p_edge | n_edge.
REQ-013 flag  out  CH  sticky per-channel flag, set by mode-qualified edges.
REQ-014 cnt  out  CH*CNT_W  per-channel qualified-edge count, channel i at [i*CNT_W +: CNT_W].
REQ-015 irq  out  1  OR of all flag bits.

Function
REQ-016 Each channel SHALL pass level through SYNC_STAGES flops; all logic downstream SHALL use only the last stage (s).
REQ-017 Per-channel FSM states: LOW, RISE_CHK, HIGH, FALL_CHK.
REQ-018 LOW: s=1 -> RISE_CHK with debounce counter = 1; else stay.
REQ-019 RISE_CHK: s=0 -> LOW, counter cleared, no pulse; s=1 -> counter++; when counter reaches DEB_CYCLES -> HIGH.
REQ-020 HIGH/FALL_CHK SHALL mirror REQ-018/019 with polarity inverted.
REQ-021 DEB_CYCLES=1: LOW->HIGH (HIGH->LOW) directly on first differing sample.
REQ-022 Entering HIGH from RISE_CHK SHALL produce a registered p_edge pulse for exactly one cycle; entering LOW from FALL_CHK likewise for n_edge.
REQ-023 Latency: pulse asserted on the clk edge SYNC_STAGES+DEB_CYCLES edges after the first edge sampling the new level, level held stable.
REQ-024 Qualified edge: (p_edge & mode[2i]) | (n_edge & mode[2i+1]).
REQ-025 flag[i] SHALL set on a qualified edge and clear on clr[i]; simultaneous set and clr -> flag = 1.
REQ-026 cnt[i] SHALL increment by 1 per qualified edge, saturating at 2^CNT_W-1 (no wrap).
REQ-027 clr[i] SHALL zero cnt[i]; simultaneous qualified edge and clr -> cnt[i] = 1.
REQ-028 mode changes SHALL take effect the next cycle and SHALL NOT alter FSM state or debounce progress.
REQ-029 Channels SHALL be fully independent; simultaneous edges on any channels all register.
REQ-030 irq SHALL be combinational OR of flag (no additional latency).

Reset
REQ-031 reset_n low: synchronizers 0, FSM LOW, debounce counters 0, p_edge/n_edge/any_edge 0, flag 0, cnt 0, irq 0.
REQ-032 For the first SYNC_STAGES+DEB_CYCLES cycles after reset release (arming window) the FSM SHALL go to LOW or HIGH directly per s, emitting no pulses, flags or counts.
REQ-033 Reset asserted mid-debounce SHALL discard pending change without pulse.

Structure
REQ-034 Shared package edge_pkg SHALL hold mode encodings (MODE_OFF/RISE/FALL/BOTH) and the FSM state typedef.
REQ-035 One sub-module edge_chan (synchronizer, debounce FSM, flag, counter for one channel) SHALL be instantiated CH times via generate; top holds irq and bus packing.

Verification (CH=4, SYNC_STAGES=2, DEB_CYCLES=3, CNT_W=8 unless stated)
REQ-036 ch0 mode=01, level[0] 0->1 held 10 cycles after arming -> single p_edge[0] 5 cycles later, flag[0]=1, cnt0=1, irq=1; n_edge stays 0.
REQ-037 ch1 mode=11, level[1] high for 2 cycles then low -> no pulses, flag[1]=0, cnt1=0.
REQ-038 ch2 mode=10, square wave period 16 for 4 periods -> 4 p_edge, 4 n_edge pulses, cnt2=4; same stimulus with mode=11 -> cnt2=8.
REQ-039 ch3 qualified edge coincident with clr[3] (flag[3]=1, cnt3=5 prior) -> flag[3]=1, cnt3=1.
REQ-040 CNT_W=4, ch0 mode=11, 20 clean edges -> cnt0=15, holds at 15.
REQ-041 level all high, reset released -> no pulses/flags during or after arming; later falling edge on ch0 -> n_edge[0] only.
